// File: rtl/game_seat_sched.sv
// Round-robin owner arbitration of one shared game_count timer across four seats.
// Loads the owner's clamped credit with a one-cycle set strobe and passes its boost through while it plays.
module game_seat_sched #(
    parameter int MW        = 10,
    parameter int MAX_MONEY = 999
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      req,
    input  logic [3:0]      quit,
    input  logic [3:0]      boost_req,
    input  logic [4*MW-1:0] money_in,
    input  logic            red_in,
    output logic [3:0]      grant,
    output logic            busy,
    output logic            set,
    output logic [MW-1:0]   money,
    output logic            boost,
    output logic [1:0]      owner
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_PLAY    = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    localparam logic [MW-1:0] MAX_C = MW'(MAX_MONEY);

    logic [2:0]    state_r;
    logic [3:0]    grant_r;
    logic          busy_r;
    logic          set_r;
    logic [MW-1:0] money_r;
    logic          boost_r;
    logic [1:0]    owner_r;

    logic [1:0]    sel_s;
    logic [MW-1:0] raw_s;
    logic [MW-1:0] credit_s;

    // Scan from last+4 down to last+1 so the seat closest after the last owner wins.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] pick;
        logic [1:0] idx;
        pick = last;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (r[idx]) begin
                pick = idx;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // Arbitration winner and its clamped credit.
    always_comb begin
        sel_s = rr_pick(req, owner_r);
        raw_s = money_in[int'(sel_s) * MW +: MW];
        if (raw_s > MAX_C) begin
            credit_s = MAX_C;
        end else begin
            credit_s = raw_s;
        end
    end

    // Session FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            grant_r <= 4'b0000;
            busy_r  <= 1'b0;
            set_r   <= 1'b0;
            money_r <= '0;
            boost_r <= 1'b0;
            owner_r <= 2'd3;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|req) begin
                        owner_r <= sel_s;
                        busy_r  <= 1'b1;
                        if (credit_s == '0) begin
                            // A zero-credit seat still takes its turn so it cannot starve others.
                            state_r <= ST_RELEASE;
                        end else begin
                            grant_r <= 4'b0001 << sel_s;
                            set_r   <= 1'b1;
                            money_r <= credit_s;
                            state_r <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    set_r   <= 1'b0;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    state_r <= ST_PLAY;
                end
                ST_PLAY: begin
                    if (red_in || quit[owner_r]) begin
                        grant_r <= 4'b0000;
                        boost_r <= 1'b0;
                        state_r <= ST_RELEASE;
                    end else begin
                        boost_r <= boost_req[owner_r];
                    end
                end
                ST_RELEASE: begin
                    grant_r <= 4'b0000;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    grant_r <= 4'b0000;
                    busy_r  <= 1'b0;
                    set_r   <= 1'b0;
                    boost_r <= 1'b0;
                end
            endcase
        end
    end

    assign grant = grant_r;
    assign busy  = busy_r;
    assign set   = set_r;
    assign money = money_r;
    assign boost = boost_r;
    assign owner = owner_r;

endmodule

// File: tb/tb_game_seat_sched.sv
// Bench for game_seat_sched: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a session-level reference model.
module tb_game_seat_sched;
    localparam int MW = 10;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      req, quit, boost_req;
    logic [4*MW-1:0] money_in;
    logic            red_in;
    logic [3:0]      grant;
    logic            busy, set, boost;
    logic [MW-1:0]   money;
    logic [1:0]      owner;

    int n_checks = 0;
    int n_fail   = 0;

    game_seat_sched #(.MW(MW), .MAX_MONEY(999)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .quit(quit), .boost_req(boost_req),
        .money_in(money_in), .red_in(red_in), .grant(grant), .busy(busy), .set(set),
        .money(money), .boost(boost), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a session is either absent, aged N cycles since its load, or releasing.
    int m_owner, m_age, m_money;
    bit m_sess, m_rel, m_boost;

    task automatic model_reset();
        m_owner = 3; m_age = 0; m_money = 0;
        m_sess = 0; m_rel = 0; m_boost = 0;
    endtask

    task automatic model_step();
        int pick;
        int c;
        if (m_rel) begin
            m_rel = 0;
        end else if (m_sess) begin
            if (m_age >= 2) begin
                if (red_in || quit[m_owner]) begin
                    m_sess = 0; m_rel = 1; m_boost = 0;
                end else begin
                    m_boost = boost_req[m_owner];
                end
            end else begin
                m_age++;
            end
        end else if (req != 4'b0000) begin
            pick = -1;
            for (int k = 1; k <= 4; k++)
                if (pick < 0 && req[(m_owner + k) % 4]) pick = (m_owner + k) % 4;
            c = int'(money_in[pick*MW +: MW]);
            if (c > 999) c = 999;
            m_owner = pick;
            if (c == 0) begin
                m_rel = 1;
            end else begin
                m_sess = 1; m_age = 0; m_money = c;
            end
        end
    endtask

    task automatic check_model();
        check("rnd_grant", grant, m_sess ? (32'd1 << m_owner) : 32'd0);
        check("rnd_set",   set,   (m_sess && m_age == 0) ? 32'd1 : 32'd0);
        check("rnd_busy",  busy,  (m_sess || m_rel) ? 32'd1 : 32'd0);
        check("rnd_money", money, m_money);
        check("rnd_boost", boost, m_boost);
        check("rnd_owner", owner, m_owner);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 4'b0; quit = 4'b0; boost_req = 4'b0; red_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] req, quit, bq;
        logic       red;
        logic [3:0] g;
        logic       s, b;
        int         m;
        logic       bo;
        int         o;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int set_cyc[$];
        logic [3:0] set_gnt[$];
        logic [3:0] exp_order[4];
        int cyc;

        // Seat credits: 50, 1020 (clamped to 999), 0 (refused), 7.
        tbl[0]  = '{4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b1, 50,  1'b0, 0};
        tbl[1]  = '{4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b1, 50,  1'b0, 0};
        tbl[2]  = '{4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b1, 50,  1'b0, 0};
        tbl[3]  = '{4'b0000, 4'b0000, 4'b0001, 1'b0, 4'b0001, 1'b0, 1'b1, 50,  1'b1, 0};
        tbl[4]  = '{4'b0000, 4'b0000, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b1, 50,  1'b0, 0};
        tbl[5]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 50,  1'b0, 0};
        tbl[6]  = '{4'b0010, 4'b0000, 4'b0000, 1'b0, 4'b0010, 1'b1, 1'b1, 999, 1'b0, 1};
        tbl[7]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0010, 1'b0, 1'b1, 999, 1'b0, 1};
        tbl[8]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0010, 1'b0, 1'b1, 999, 1'b0, 1};
        tbl[9]  = '{4'b0000, 4'b0000, 4'b0001, 1'b0, 4'b0010, 1'b0, 1'b1, 999, 1'b0, 1};
        tbl[10] = '{4'b0000, 4'b0000, 4'b0010, 1'b0, 4'b0010, 1'b0, 1'b1, 999, 1'b1, 1};
        tbl[11] = '{4'b0000, 4'b0001, 4'b0010, 1'b0, 4'b0010, 1'b0, 1'b1, 999, 1'b1, 1};
        tbl[12] = '{4'b0000, 4'b0010, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b1, 999, 1'b0, 1};
        tbl[13] = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 999, 1'b0, 1};
        tbl[14] = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 999, 1'b0, 2};
        tbl[15] = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 999, 1'b0, 2};
        tbl[16] = '{4'b1100, 4'b0000, 4'b0000, 1'b0, 4'b1000, 1'b1, 1'b1, 7,   1'b0, 3};
        tbl[17] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b1, 7,   1'b0, 3};

        money_in = {10'd7, 10'd0, 10'd1020, 10'd50};
        do_reset();
        check("rst_grant", grant, 4'b0000);
        check("rst_busy",  busy,  1'b0);
        check("rst_owner", owner, 2'd3);
        check("rst_money", money, 0);

        for (int i = 0; i < 18; i++) begin
            req = tbl[i].req; quit = tbl[i].quit; boost_req = tbl[i].bq; red_in = tbl[i].red;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_grant", i), grant, tbl[i].g);
            check($sformatf("v%0d_set", i),   set,   tbl[i].s);
            check($sformatf("v%0d_busy", i),  busy,  tbl[i].b);
            check($sformatf("v%0d_money", i), money, tbl[i].m);
            check($sformatf("v%0d_boost", i), boost, tbl[i].bo);
            check($sformatf("v%0d_owner", i), owner, tbl[i].o);
            @(negedge clk);
        end

        // Round-robin with red held: each session is LOAD, WAIT, PLAY, RELEASE, IDLE.
        exp_order = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
        money_in = {10'd40, 10'd30, 10'd20, 10'd10};
        do_reset();
        req = 4'b1011; red_in = 1'b1;
        cyc = 0;
        while (set_cyc.size() < 4 && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (set) begin
                set_cyc.push_back(cyc);
                set_gnt.push_back(grant);
            end
            @(negedge clk);
        end
        check("rr_sessions", set_cyc.size(), 4);
        for (int i = 0; i < set_gnt.size(); i++) begin
            check($sformatf("rr_grant%0d", i), set_gnt[i], exp_order[i]);
            if (i > 0) check($sformatf("rr_gap%0d", i), set_cyc[i] - set_cyc[i-1], 5);
        end

        // Asynchronous reset in the middle of a boosted session owned by seat 2.
        money_in = {10'd0, 10'd100, 10'd0, 10'd0};
        do_reset();
        req = 4'b0100;
        repeat (3) @(negedge clk);
        boost_req = 4'b0100;
        @(negedge clk);
        check("mid_boost", boost, 1'b1);
        check("mid_owner", owner, 2'd2);
        check("mid_grant", grant, 4'b0100);
        #2 rst_n = 1'b0;
        #1;
        check("arst_grant", grant, 4'b0000);
        check("arst_busy",  busy,  1'b0);
        check("arst_set",   set,   1'b0);
        check("arst_boost", boost, 1'b0);
        check("arst_owner", owner, 2'd3);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            if (n % 7 == 0) begin
                for (int s = 0; s < 4; s++) begin
                    int r;
                    r = $urandom_range(0, 9);
                    if (r == 0)      money_in[s*MW +: MW] = '0;
                    else if (r == 1) money_in[s*MW +: MW] = MW'($urandom_range(1000, 1023));
                    else             money_in[s*MW +: MW] = MW'($urandom_range(1, 999));
                end
            end
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            quit      = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            red_in    = ($urandom_range(0, 9) == 0);
            boost_req = 4'($urandom_range(0, 15));
            @(posedge clk);
            model_step();
            #1;
            check_model();
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/game_seat_sched.md
Name: game_seat_sched

Overview:
- Round-robin scheduler that shares one game_count timer between 4 player seats.
- Grants the timer to one requesting seat at a time and loads that seat's credit via a one-cycle set pulse.
- Passes the owner's boost request through to the timer while the session runs.
- Releases the timer when the timer reports empty (red) or the owner quits.
- Sits between the seat front-ends and game_count; its outputs connect directly to game_count's set/money/boost inputs.

Parameters:
- MW, 10: money/credit width; matches game_count money and remain.
- MAX_MONEY, 999: credit ceiling; captured credit above this is clamped.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  4  per-seat request; level, held while the seat wants the timer.
- quit  in  4  per-seat quit; only the bit of the current owner is honoured.
- boost_req  in  4  per-seat boost request.
- money_in  in  4*MW  per-seat credit; seat i occupies bits [i*MW +: MW].
- red_in  in  1  game_count red (remaining time exhausted).
- grant  out  4  one-hot owner indication; all zero when no seat owns the timer.
- busy  out  1  high in every state except IDLE.
- set  out  1  one-cycle load strobe to game_count.
- money  out  MW  credit value to game_count; valid while set=1, otherwise holds its last value.
- boost  out  1  boost to game_count.
- owner  out  2  index of the current or last owner.

Behaviour:
- Reset (async, rst_n=0), all outputs registered:
  - grant=0, busy=0, set=0, money=0, boost=0, owner=3, state=IDLE.
  - owner=3 makes seat 0 the first-priority seat.
- FSM states: IDLE, LOAD, WAIT, PLAY, RELEASE.
- IDLE, no req bit set: stay in IDLE.
- IDLE, any req bit set:
  - Select the first set bit scanning owner+1, owner+2, … modulo 4.
  - Capture c = min(money_in[sel], MAX_MONEY).
  - If c==0: the seat is refused. Update owner=sel, go to RELEASE; grant and set stay 0.
  - Otherwise on the next edge: owner=sel, grant=1<<sel, set=1, money=c, busy=1, state=LOAD.
- LOAD: exactly one cycle. Next edge: set=0, state=WAIT.
- WAIT: one cycle to let game_count settle. red_in is ignored in LOAD and WAIT. Next edge: state=PLAY.
- PLAY:
  - boost is registered from boost_req[owner] each cycle (1-cycle lag).
  - If red_in=1 or quit[owner]=1: next edge grant=0, boost=0, state=RELEASE.
  - Quit and red in the same cycle are treated as a single release.
  - quit/boost_req bits of non-owners are ignored.
  - A drop of req[owner] during PLAY does not release; only quit or red releases.
- RELEASE: one cycle, busy=1, grant=0. Next edge: state=IDLE, busy=0.
- Turnaround: minimum 2 cycles after the last PLAY cycle (RELEASE, IDLE) before the next LOAD.
- Fairness: the seat just served has the lowest priority in the next arbitration.
  - A refused seat (c==0) also rotates the pointer, so it cannot block other seats.
- Requests change only the IDLE decision; req edges in other states have no effect.
- Reset mid-session: immediately forces the reset values; the session is abandoned.
  - game_count is not reloaded; it sees set=0 and boost=0.

Test Plan:
- Reset defaults: rst_n=0 mid-PLAY (seat 2 owner, boost=1) -> same cycle grant=0, busy=0, set=0, boost=0, owner=3.
- Single seat: req=0001, money_in[0]=50 -> next edge grant=0001, set=1 for exactly 1 cycle, money=50. Then WAIT, PLAY. red_in=1 -> grant=0 on the next edge, busy=0 two edges later.
- Round-robin: req=1011 held, each session ended by red_in -> grant order 0001, 0010, 1000, 0001. Each LOAD is separated from the previous PLAY exit by RELEASE+IDLE.
- Clamp and zero credit:
  - money_in[1]=1020 -> money=999.
  - money_in[2]=0 with req=0100 -> set never pulses, grant stays 0, owner=2, FSM returns to IDLE after RELEASE.
- Quit and boost isolation: seat 1 owner in PLAY; boost_req=0001 -> boost=0. boost_req=0010 -> boost=1 one cycle later. quit=0001 -> ignored. quit=0010 -> release.
- Red ignored early: red_in=1 held from grant through WAIT -> session still reaches PLAY, then releases on the first PLAY cycle.
